// File: rtl/mips_pkg.sv
// Shared decode constants for the 16-bit MIPS-style pipeline: opcodes, field positions,
// the canonical NOP encoding and the 6-bit immediate sign extension.
package mips_pkg;

  localparam int WORD_W = 16;

  localparam int OP_MSB  = 15;
  localparam int OP_LSB  = 12;
  localparam int RS_MSB  = 11;
  localparam int RS_LSB  = 9;
  localparam int RT_MSB  = 8;
  localparam int RT_LSB  = 6;
  localparam int RD_MSB  = 5;
  localparam int RD_LSB  = 3;
  localparam int IMM_MSB = 5;

  localparam logic [3:0] OP_RTYPE = 4'd0;
  localparam logic [3:0] OP_ADDI  = 4'd1;
  localparam logic [3:0] OP_LW    = 4'd2;
  localparam logic [3:0] OP_SW    = 4'd3;
  localparam logic [3:0] OP_BEQ   = 4'd4;
  localparam logic [3:0] OP_BNE   = 4'd5;

  localparam logic [15:0] NOP = 16'h0000;

  function automatic logic [WORD_W-1:0] sign_ext6(input logic [5:0] imm);
    return {{(WORD_W-6){imm[5]}}, imm};
  endfunction

endpackage

// File: rtl/id_stage_reg_file.sv
// 2-read/1-write register file with r0 hardwired to zero.
// With ID_WB_BYPASS_EN defined, a same-cycle writeback is forwarded to the read ports.
module reg_file
  import mips_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int NREG   = 8,
  parameter int AW     = $clog2(NREG)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [AW-1:0]     ra_addr,
  input  logic [AW-1:0]     rb_addr,
  output logic [DATA_W-1:0] ra_data,
  output logic [DATA_W-1:0] rb_data,
  input  logic              we,
  input  logic [AW-1:0]     wa,
  input  logic [DATA_W-1:0] wd
);

  logic [DATA_W-1:0] regs [NREG];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (we && wa != '0) begin
      regs[wa] <= wd;
    end
  end

  always_comb begin
    ra_data = regs[ra_addr];
    rb_data = regs[rb_addr];
`ifdef ID_WB_BYPASS_EN
    if (we && wa == ra_addr) ra_data = wd;
    if (we && wa == rb_addr) rb_data = wd;
`endif
    if (ra_addr == '0) ra_data = '0;
    if (rb_addr == '0) rb_data = '0;
  end

endmodule

// File: rtl/id_stage.sv
// Decode stage: IF/ID register, register read, BEQ/BNE resolution, hazard stalls and ID/EX launch.
// ID_WB_BYPASS_EN selects write-through register reads instead of a stall on a writeback match.
module id_stage
  import mips_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int PC_W   = 8,
  parameter int NREG   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [PC_W-1:0]   pc_in,
  input  logic [15:0]       instr_in,
  input  logic              wb_en,
  input  logic [2:0]        wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              mem_wr_en,
  input  logic [2:0]        mem_wr_addr,
  output logic              instr_fetch_enable,
  output logic              branch_enable,
  output logic [5:0]        imm_branch_offset,
  output logic              ex_valid,
  output logic [3:0]        ex_op,
  output logic [DATA_W-1:0] ex_rs_val,
  output logic [DATA_W-1:0] ex_rt_val,
  output logic [2:0]        ex_rd,
  output logic [DATA_W-1:0] ex_imm,
  output logic [PC_W-1:0]   ex_pc
);

  logic [PC_W-1:0]   ifid_pc;
  logic [15:0]       ifid_instr;
  logic [3:0]        op;
  logic [2:0]        rs, rt, rd, dest;
  logic [5:0]        imm6;
  logic              is_nop, is_branch, use_rs, use_rt;
  logic              lu_stall, br_stall, wb_stall, stall;
  logic [DATA_W-1:0] rs_val, rt_val;

  assign op   = ifid_instr[OP_MSB:OP_LSB];
  assign rs   = ifid_instr[RS_MSB:RS_LSB];
  assign rt   = ifid_instr[RT_MSB:RT_LSB];
  assign rd   = ifid_instr[RD_MSB:RD_LSB];
  assign imm6 = ifid_instr[IMM_MSB:0];

  // True when register a is a live source of the instruction in IF/ID; r0 never creates a hazard.
  function automatic logic src_hit(input logic [2:0] a, input logic [2:0] s, input logic [2:0] t,
                                   input logic us, input logic ut);
    return (a != 3'd0) && ((us && s == a) || (ut && t == a));
  endfunction

  always_comb begin
    is_nop    = (ifid_instr == NOP) || (op > OP_BNE);
    is_branch = !is_nop && (op == OP_BEQ || op == OP_BNE);
    use_rs    = !is_nop;
    use_rt    = !is_nop && (op == OP_RTYPE || op == OP_SW || is_branch);
    dest      = 3'd0;
    if (!is_nop) begin
      case (op)
        OP_RTYPE:      dest = rd;
        OP_ADDI, OP_LW: dest = rt;
        default:       dest = 3'd0;
      endcase
    end
  end

  reg_file #(.DATA_W(DATA_W), .NREG(NREG)) u_reg_file (
    .clk     (clk),
    .rst     (rst),
    .ra_addr (rs),
    .rb_addr (rt),
    .ra_data (rs_val),
    .rb_data (rt_val),
    .we      (wb_en),
    .wa      (wb_addr),
    .wd      (wb_data)
  );

  // Non-writing ops carry ex_rd = 0 into ID/EX, so a nonzero valid ex_rd always means a pending write.
  assign lu_stall = ex_valid && ex_op == OP_LW && src_hit(ex_rd, rs, rt, use_rs, use_rt);
  assign br_stall = is_branch &&
                    ((ex_valid && src_hit(ex_rd, rs, rt, use_rs, use_rt)) ||
                     (mem_wr_en && src_hit(mem_wr_addr, rs, rt, use_rs, use_rt)));
`ifdef ID_WB_BYPASS_EN
  assign wb_stall = 1'b0;
`else
  assign wb_stall = wb_en && src_hit(wb_addr, rs, rt, use_rs, use_rt);
`endif
  assign stall = lu_stall || br_stall || wb_stall;

  assign instr_fetch_enable = !stall;
  assign branch_enable      = is_branch && !stall && ((op == OP_BEQ) == (rs_val == rt_val));
  assign imm_branch_offset  = imm6;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ifid_pc    <= '0;
      ifid_instr <= NOP;
    end else if (!stall) begin
      ifid_pc    <= pc_in;
      ifid_instr <= instr_in;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ex_valid  <= 1'b0;
      ex_op     <= '0;
      ex_rd     <= '0;
      ex_rs_val <= '0;
      ex_rt_val <= '0;
      ex_imm    <= '0;
      ex_pc     <= '0;
    end else if (stall || is_nop) begin
      ex_valid  <= 1'b0;
      ex_op     <= '0;
      ex_rd     <= '0;
      ex_rs_val <= '0;
      ex_rt_val <= '0;
      ex_imm    <= '0;
      ex_pc     <= '0;
    end else begin
      ex_valid  <= 1'b1;
      ex_op     <= op;
      ex_rd     <= dest;
      ex_rs_val <= rs_val;
      ex_rt_val <= rt_val;
      ex_imm    <= DATA_W'(sign_ext6(imm6));
      ex_pc     <= ifid_pc;
    end
  end

endmodule

// File: tb/tb_id_stage.sv
// Bench for id_stage: directed hazard/branch scenarios plus a randomized run against a
// rule-level reference model. Follows ID_WB_BYPASS_EN the same way the design does.
`timescale 1ns/1ps
module tb_id_stage;
  import mips_pkg::*;

`ifdef ID_WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  pc_in;
  logic [15:0] instr_in;
  logic        wb_en;
  logic [2:0]  wb_addr;
  logic [15:0] wb_data;
  logic        mem_wr_en;
  logic [2:0]  mem_wr_addr;
  logic        instr_fetch_enable, branch_enable, ex_valid;
  logic [5:0]  imm_branch_offset;
  logic [3:0]  ex_op;
  logic [15:0] ex_rs_val, ex_rt_val, ex_imm;
  logic [2:0]  ex_rd;
  logic [7:0]  ex_pc;

  int n_chk = 0;
  int n_fail = 0;
  logic [7:0] pc_cnt = 8'h10;

  // reference model state
  logic [15:0] m_regs [8];
  logic [7:0]  m_ifid_pc;
  logic [15:0] m_ifid_instr;
  logic        m_ex_valid;
  logic [3:0]  m_ex_op;
  logic [2:0]  m_ex_rd;
  logic [15:0] m_ex_rs, m_ex_rt, m_ex_imm;
  logic [7:0]  m_ex_pc;

  always #5 clk = ~clk;

  id_stage dut (
    .clk(clk), .rst(rst), .pc_in(pc_in), .instr_in(instr_in),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr),
    .instr_fetch_enable(instr_fetch_enable), .branch_enable(branch_enable),
    .imm_branch_offset(imm_branch_offset), .ex_valid(ex_valid), .ex_op(ex_op),
    .ex_rs_val(ex_rs_val), .ex_rt_val(ex_rt_val), .ex_rd(ex_rd),
    .ex_imm(ex_imm), .ex_pc(ex_pc)
  );

  function automatic logic [15:0] enc_r(input logic [2:0] s, input logic [2:0] t, input logic [2:0] d);
    return {OP_RTYPE, s, t, d, 3'b000};
  endfunction

  function automatic logic [15:0] enc_i(input logic [3:0] o, input logic [2:0] s, input logic [2:0] t,
                                        input logic [5:0] imm);
    return {o, s, t, imm};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic [15:0] i, input logic we = 1'b0, input logic [2:0] wa = 3'd0,
                        input logic [15:0] wd = 16'h0, input logic me = 1'b0, input logic [2:0] ma = 3'd0);
    instr_in = i; wb_en = we; wb_addr = wa; wb_data = wd; mem_wr_en = me; mem_wr_addr = ma;
    pc_in = pc_cnt;
    pc_cnt = pc_cnt + 8'd1;
  endtask

  // ---- reference model: instruction semantics stated directly from the ISA rules ----
  function automatic bit m_nop(input logic [15:0] i);
    return (i == 16'h0000) || (i[15:12] > 4'd5);
  endfunction

  function automatic bit m_reads(input logic [15:0] i, input logic [2:0] r);
    logic [3:0] o;
    o = i[15:12];
    if (r == 3'd0 || m_nop(i)) return 1'b0;
    if (i[11:9] == r) return 1'b1;
    return (o == 4'd0 || o == 4'd3 || o == 4'd4 || o == 4'd5) && (i[8:6] == r);
  endfunction

  function automatic logic [2:0] m_dest(input logic [15:0] i);
    if (m_nop(i)) return 3'd0;
    if (i[15:12] == 4'd0) return i[5:3];
    if (i[15:12] == 4'd1 || i[15:12] == 4'd2) return i[8:6];
    return 3'd0;
  endfunction

  function automatic logic [15:0] m_read(input logic [2:0] a, input logic we, input logic [2:0] wa,
                                         input logic [15:0] wd);
    if (a == 3'd0) return 16'h0;
    if (BYP && we && wa == a) return wd;
    return m_regs[a];
  endfunction

  task automatic test_reset;
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      pc_in = 8'($urandom); instr_in = 16'($urandom); wb_en = 1'($urandom);
      wb_addr = 3'($urandom); wb_data = 16'($urandom);
      mem_wr_en = 1'($urandom); mem_wr_addr = 3'($urandom);
      #2;
      n_chk++; if (ex_valid !== 1'b0) begin n_fail++; $display("FAIL reset_ex_valid: got %b want 0", ex_valid); end
      n_chk++; if (ex_op !== 4'd0) begin n_fail++; $display("FAIL reset_ex_op: got %0d want 0", ex_op); end
      n_chk++; if (instr_fetch_enable !== 1'b1) begin n_fail++; $display("FAIL reset_fetch_en: got %b want 1", instr_fetch_enable); end
      n_chk++; if (branch_enable !== 1'b0) begin n_fail++; $display("FAIL reset_branch_en: got %b want 0", branch_enable); end
      tick;
    end
    set_in(NOP);
    rst = 1'b1;
  endtask

  task automatic test_wb_hazard;
    set_in(enc_i(OP_ADDI, 3'd0, 3'd1, 6'd5)); tick;
    set_in(enc_r(3'd1, 3'd1, 3'd2)); #2;
    n_chk++; if (instr_fetch_enable !== 1'b1) begin n_fail++; $display("FAIL addi_no_stall: got %b want 1", instr_fetch_enable); end
    tick;
    set_in(NOP, 1'b1, 3'd1, 16'd5); #2;
    n_chk++; if (instr_fetch_enable !== BYP) begin n_fail++; $display("FAIL wb_match_stall: fetch_en got %b want %b", instr_fetch_enable, BYP); end
    n_chk++; if ({ex_valid, ex_op, ex_rd, ex_imm} !== {1'b1, OP_ADDI, 3'd1, 16'd5})
      begin n_fail++; $display("FAIL addi_issue: got %b/%0d/%0d/%h want 1/1/1/0005", ex_valid, ex_op, ex_rd, ex_imm); end
    tick;
    set_in(NOP); #2;
    n_chk++; if (ex_valid !== BYP) begin n_fail++; $display("FAIL add_issue_timing: ex_valid got %b want %b", ex_valid, BYP); end
    if (!BYP) begin tick; set_in(NOP); #2; end
    n_chk++; if ({ex_valid, ex_op, ex_rd} !== {1'b1, OP_RTYPE, 3'd2})
      begin n_fail++; $display("FAIL add_decode: got %b/%0d/%0d want 1/0/2", ex_valid, ex_op, ex_rd); end
    n_chk++; if ({ex_rs_val, ex_rt_val} !== {16'd5, 16'd5})
      begin n_fail++; $display("FAIL add_operands: got %h/%h want 0005/0005", ex_rs_val, ex_rt_val); end
    tick;
  endtask

  task automatic test_load_use;
    logic [7:0] add_pc;
    set_in(enc_i(OP_LW, 3'd0, 3'd3, 6'd2)); tick;
    set_in(enc_r(3'd3, 3'd0, 3'd4)); add_pc = pc_in; #2;
    n_chk++; if (instr_fetch_enable !== 1'b1) begin n_fail++; $display("FAIL lw_no_stall: got %b want 1", instr_fetch_enable); end
    tick;
    set_in(NOP); #2;
    n_chk++; if (instr_fetch_enable !== 1'b0) begin n_fail++; $display("FAIL lu_stall: fetch_en got %b want 0", instr_fetch_enable); end
    n_chk++; if ({ex_valid, ex_op} !== {1'b1, OP_LW}) begin n_fail++; $display("FAIL lw_issue: got %b/%0d want 1/2", ex_valid, ex_op); end
    tick;
    set_in(NOP); #2;
    n_chk++; if ({ex_valid, ex_op, ex_rd} !== 8'd0) begin n_fail++; $display("FAIL lu_bubble: got %b/%0d/%0d want 0/0/0", ex_valid, ex_op, ex_rd); end
    n_chk++; if (instr_fetch_enable !== 1'b1) begin n_fail++; $display("FAIL lu_one_cycle: fetch_en got %b want 1", instr_fetch_enable); end
    tick;
    set_in(NOP); #2;
    n_chk++; if ({ex_valid, ex_rd, ex_pc} !== {1'b1, 3'd4, add_pc})
      begin n_fail++; $display("FAIL lu_held_issue: got %b/%0d/pc %h want 1/4/pc %h", ex_valid, ex_rd, ex_pc, add_pc); end
    tick;
  endtask

  task automatic test_branch;
    set_in(NOP, 1'b1, 3'd1, 16'd7); tick;
    set_in(NOP, 1'b1, 3'd2, 16'd7); tick;
    set_in(enc_i(OP_BEQ, 3'd1, 3'd2, 6'h3E)); tick;
    set_in(NOP); #2;
    n_chk++; if ({branch_enable, instr_fetch_enable} !== 2'b11) begin n_fail++; $display("FAIL beq_taken: br/fetch got %b%b want 11", branch_enable, instr_fetch_enable); end
    n_chk++; if (imm_branch_offset !== 6'h3E) begin n_fail++; $display("FAIL beq_offset: got %h want 3e", imm_branch_offset); end
    tick;
    set_in(NOP); #2;
    n_chk++; if ({ex_valid, ex_op, ex_rd, branch_enable} !== {1'b1, OP_BEQ, 3'd0, 1'b0})
      begin n_fail++; $display("FAIL beq_to_ex: got %b/%0d/%0d/br %b want 1/4/0/br 0", ex_valid, ex_op, ex_rd, branch_enable); end
    tick;
    set_in(NOP); #2;
    n_chk++; if (ex_valid !== 1'b0) begin n_fail++; $display("FAIL squash_nop: ex_valid got %b want 0", ex_valid); end
    tick;
    set_in(NOP, 1'b1, 3'd2, 16'd8); tick;
    set_in(enc_i(OP_BEQ, 3'd1, 3'd2, 6'h3E)); tick;
    set_in(NOP); #2;
    n_chk++; if ({branch_enable, instr_fetch_enable} !== 2'b01) begin n_fail++; $display("FAIL beq_not_taken: br/fetch got %b%b want 01", branch_enable, instr_fetch_enable); end
    tick;
  endtask

  task automatic test_bne_hazard;
    set_in(enc_i(OP_ADDI, 3'd0, 3'd5, 6'd9)); tick;
    set_in(enc_i(OP_BNE, 3'd5, 3'd0, 6'd3)); tick;
    set_in(NOP); #2;
    n_chk++; if ({instr_fetch_enable, branch_enable} !== 2'b00) begin n_fail++; $display("FAIL bne_stall_ex: fetch/br got %b%b want 00", instr_fetch_enable, branch_enable); end
    tick;
    set_in(NOP, 1'b0, 3'd0, 16'd0, 1'b1, 3'd5); #2;
    n_chk++; if ({instr_fetch_enable, branch_enable} !== 2'b00) begin n_fail++; $display("FAIL bne_stall_mem: fetch/br got %b%b want 00", instr_fetch_enable, branch_enable); end
    tick;
    set_in(NOP, 1'b1, 3'd5, 16'd9); #2;
    n_chk++; if (instr_fetch_enable !== BYP) begin n_fail++; $display("FAIL bne_wb_cycle: fetch_en got %b want %b", instr_fetch_enable, BYP); end
    if (!BYP) begin tick; set_in(NOP); #2; end
    n_chk++; if ({instr_fetch_enable, branch_enable, imm_branch_offset} !== {2'b11, 6'd3})
      begin n_fail++; $display("FAIL bne_resolve: fetch/br/off got %b%b/%h want 11/03", instr_fetch_enable, branch_enable, imm_branch_offset); end
    tick;
    set_in(NOP); tick;
  endtask

  task automatic test_r0;
    set_in(enc_r(3'd0, 3'd0, 3'd7)); tick;
    set_in(enc_r(3'd0, 3'd0, 3'd7), 1'b1, 3'd0, 16'hFFFF); #2;
    n_chk++; if (instr_fetch_enable !== 1'b1) begin n_fail++; $display("FAIL r0_no_hazard: fetch_en got %b want 1", instr_fetch_enable); end
    tick;
    set_in(NOP); #2;
    n_chk++; if ({ex_valid, ex_rs_val, ex_rt_val} !== {1'b1, 32'h0}) begin n_fail++; $display("FAIL r0_read_during_wb: got %b/%h/%h want 1/0000/0000", ex_valid, ex_rs_val, ex_rt_val); end
    tick;
    set_in(NOP); #2;
    n_chk++; if ({ex_valid, ex_rs_val, ex_rt_val} !== {1'b1, 32'h0}) begin n_fail++; $display("FAIL r0_read_after_wb: got %b/%h/%h want 1/0000/0000", ex_valid, ex_rs_val, ex_rt_val); end
    tick;
  endtask

  task automatic test_reset_mid_stall;
    set_in(enc_i(OP_LW, 3'd0, 3'd3, 6'd1)); tick;
    set_in(enc_r(3'd3, 3'd0, 3'd4)); tick;
    set_in(NOP); #2;
    n_chk++; if (instr_fetch_enable !== 1'b0) begin n_fail++; $display("FAIL mid_stall_setup: fetch_en got %b want 0", instr_fetch_enable); end
    #1 rst = 1'b0;
    #1;
    n_chk++; if ({ex_valid, ex_op, ex_rd, instr_fetch_enable, branch_enable} !== {1'b0, 4'd0, 3'd0, 1'b1, 1'b0})
      begin n_fail++; $display("FAIL reset_mid_stall: got v%b op%0d rd%0d fe%b br%b want v0 op0 rd0 fe1 br0", ex_valid, ex_op, ex_rd, instr_fetch_enable, branch_enable); end
    tick;
    rst = 1'b1;
    set_in(enc_r(3'd1, 3'd2, 3'd6)); tick;
    set_in(NOP); #2;
    n_chk++; if (ex_valid !== 1'b0) begin n_fail++; $display("FAIL post_reset_bubble: ex_valid got %b want 0", ex_valid); end
    tick;
    set_in(NOP); #2;
    n_chk++; if ({ex_valid, ex_rd, ex_rs_val, ex_rt_val} !== {1'b1, 3'd6, 32'h0})
      begin n_fail++; $display("FAIL post_reset_regs: got %b/%0d/%h/%h want 1/6/0000/0000", ex_valid, ex_rd, ex_rs_val, ex_rt_val); end
    tick;
  endtask

  task automatic test_random;
    logic [15:0] ins, rsv, rtv, wd;
    logic [2:0]  wa, ma;
    logic [3:0]  o;
    logic        we, me, isbr, stall, taken;
    int          v;
    rst = 1'b0; set_in(NOP); tick;
    rst = 1'b1;
    for (int r = 0; r < 8; r++) m_regs[r] = 16'h0;
    m_ifid_pc = 8'h0; m_ifid_instr = 16'h0;
    {m_ex_valid, m_ex_op, m_ex_rd, m_ex_rs, m_ex_rt, m_ex_imm, m_ex_pc} = '0;
    for (int c = 0; c < 600; c++) begin
      we = ($urandom_range(0, 3) == 0); wa = 3'($urandom_range(0, 3)); wd = 16'($urandom);
      me = ($urandom_range(0, 3) == 0); ma = 3'($urandom_range(0, 3));
      o = m_ifid_instr[15:12];
      isbr = !m_nop(m_ifid_instr) && (o == 4'd4 || o == 4'd5);
      stall = (m_ex_valid && m_ex_op == 4'd2 && m_reads(m_ifid_instr, m_ex_rd)) ||
              (isbr && ((m_ex_valid && m_reads(m_ifid_instr, m_ex_rd)) || (me && m_reads(m_ifid_instr, ma)))) ||
              (!BYP && we && m_reads(m_ifid_instr, wa));
      rsv = m_read(m_ifid_instr[11:9], we, wa, wd);
      rtv = m_read(m_ifid_instr[8:6], we, wa, wd);
      taken = isbr && !stall && ((o == 4'd4) ? (rsv == rtv) : (rsv != rtv));
      if (taken || $urandom_range(0, 9) == 0) ins = 16'h0000;
      else ins = {4'($urandom_range(0, 6)), 3'($urandom_range(0, 3)), 3'($urandom_range(0, 3)), 6'($urandom)};
      set_in(ins, we, wa, wd, me, ma);
      #2;
      n_chk++;
      if ({instr_fetch_enable, branch_enable, imm_branch_offset} !== {!stall, taken, m_ifid_instr[5:0]}) begin
        n_fail++;
        $display("FAIL rand_fetch_ctl cycle %0d: fe/br/off got %b/%b/%h want %b/%b/%h", c,
                 instr_fetch_enable, branch_enable, imm_branch_offset, !stall, taken, m_ifid_instr[5:0]);
      end
      n_chk++;
      if ({ex_valid, ex_op, ex_rd, ex_rs_val, ex_rt_val, ex_imm, ex_pc} !==
          {m_ex_valid, m_ex_op, m_ex_rd, m_ex_rs, m_ex_rt, m_ex_imm, m_ex_pc}) begin
        n_fail++;
        $display("FAIL rand_idex cycle %0d: got v%b op%0d rd%0d %h %h %h pc%h want v%b op%0d rd%0d %h %h %h pc%h", c,
                 ex_valid, ex_op, ex_rd, ex_rs_val, ex_rt_val, ex_imm, ex_pc,
                 m_ex_valid, m_ex_op, m_ex_rd, m_ex_rs, m_ex_rt, m_ex_imm, m_ex_pc);
      end
      if (we && wa != 3'd0) m_regs[wa] = wd;
      if (stall || m_nop(m_ifid_instr)) begin
        {m_ex_valid, m_ex_op, m_ex_rd, m_ex_rs, m_ex_rt, m_ex_imm, m_ex_pc} = '0;
      end else begin
        v = int'(m_ifid_instr[5:0]);
        if (v >= 32) v = v - 64;
        m_ex_valid = 1'b1; m_ex_op = o; m_ex_rd = m_dest(m_ifid_instr);
        m_ex_rs = rsv; m_ex_rt = rtv; m_ex_imm = 16'(v); m_ex_pc = m_ifid_pc;
      end
      if (!stall) begin m_ifid_pc = pc_in; m_ifid_instr = ins; end
      tick;
    end
  endtask

  initial begin
    test_reset;
    tick;
    test_wb_hazard;
    test_load_use;
    test_branch;
    test_bne_hazard;
    test_r0;
    test_reset_mid_stall;
    test_random;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
